vga_capture: RTL and testbench
==============================

Name: vga_capture

Overview:
- Receive side of the 640x480 VGA display interface: samples incoming Hsync/Vsync/RGB at the 25 MHz pixel strobe.
- Rebuilds pixel coordinates, checks line and frame timing against the nominal mode, and locks onto the stream.
- Forwards active-area pixels with a valid flag.
- Used for loopback self-test of the game display and as the front end of a frame-checking monitor.

Parameters:
- H_ACTIVE, 640, active pixels per line
- H_SYNC, 96, Hsync pulse width in strobes
- H_BP, 48, horizontal back porch in strobes
- H_TOTAL, 800, strobes per line
- V_ACTIVE, 480, active lines per frame
- V_SYNC, 2, Vsync pulse width in lines
- V_BP, 33, vertical back porch in lines
- V_TOTAL, 525, lines per frame
- LOCK_FRAMES, 2, consecutive good frames required to lock (1..15)

Ports:
- in_clock  in  1  system clock, 50 MHz
- in_reset  in  1  asynchronous, active-low reset
- in_pixel_stb  in  1  one-cycle pixel strobe; all sampling is qualified by it
- in_Hsync  in  1  horizontal sync, active low
- in_Vsync  in  1  vertical sync, active low
- in_r, in_g, in_b  in  4 each  incoming colour
- out_x  out  10  active-area x, 0..639
- out_y  out  9  active-area y, 0..479
- out_r, out_g, out_b  out  4 each  registered colour
- out_pixel_valid  out  1  high one cycle per active pixel while locked
- out_frame_start  out  1  one-cycle pulse on each Vsync assertion
- out_locked  out  1  timing lock status
- out_err  out  1  one-cycle pulse on a timing violation while MEASURE or LOCKED

Behaviour:
- Reset (in_reset low, async): all outputs 0, counters 0, FSM in SEARCH, sync history registers 1 (deasserted).
- Nothing advances when in_pixel_stb is low.
- Sync edge detection: an edge is a 1->0 transition of the registered previous sample vs. the current sample.
- hcnt (10 bit):
  - Cleared to 0 on an Hsync edge, otherwise +1 per strobe.
  - Saturates at 1023.
- vcnt (10 bit):
  - +1 on each Hsync edge.
  - Cleared on a Vsync edge; a Vsync edge takes priority when both edges occur on the same strobe.
- Active window: hcnt in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE-1] AND vcnt in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE-1].
  - out_x = hcnt-(H_SYNC+H_BP)
  - out_y = vcnt-(V_SYNC+V_BP), truncated to 9 bits.
- Latency: out_x/out_y/out_r/g/b/out_pixel_valid register on the sampling strobe cycle and are presented on the next in_clock cycle.
  - out_pixel_valid is a single-cycle pulse.
  - out_x/out_y/RGB hold until the next strobe.
- Line check: on an Hsync edge, the finished line length is hcnt+1 and must equal H_TOTAL.
  - The first line after SEARCH is not checked.
- Frame check: on a Vsync edge, the finished frame length is vcnt and must equal V_TOTAL.
- FSM:
  - SEARCH: wait for a Vsync edge -> MEASURE, good-frame count = 0.
  - MEASURE: a line or frame mismatch -> out_err pulse, SEARCH. Each good frame end increments the count. When count reaches LOCKED_FRAMES -> LOCKED, out_locked = 1.
  - LOCKED: any mismatch, or hcnt reaching 1023 (lost Hsync) -> out_err pulse, out_locked = 0, SEARCH.
- out_frame_start pulses on every Vsync edge in any state.
- Reset mid-frame: everything returns to SEARCH immediately, with no pulses on release.

Optional Feature:
- Macro VGA_CAPTURE_CHECKSUM_EN.
- When defined:
  - Adds port out_checksum (out, 16).
  - A running 16-bit sum of {in_r,in_g,in_b} over all valid pixels, wrapping modulo 2^16.
  - Latched to out_checksum on each Vsync edge while LOCKED; the accumulator then clears.
  - out_checksum resets to 0.
- When undefined: port and logic are absent.

Test Plan:
- Nominal 800x525 stream, LOCK_FRAMES=2 -> out_locked rises at the 3rd Vsync edge; first valid pixel has out_x=0, out_y=0 at hcnt=144, vcnt=35; 307200 valid pulses per locked frame.
- Solid colour R=F, G=0, B=A at pixel (639,479) -> out_r=F, out_g=0, out_b=A, out_x=639, out_y=479, one cycle after its strobe.
- While locked, one line shortened to 799 strobes -> out_err pulse on that Hsync edge, out_locked=0, no valid pulses until relock 2 frames later.
- Hsync held high while locked -> out_err when hcnt hits 1023, return to SEARCH.
- Async reset asserted mid-line at x=300 -> all outputs 0 immediately, no out_frame_start pulse after release until the next Vsync edge.
- With VGA_CAPTURE_CHECKSUM_EN, all pixels 12'h001 -> out_checksum = 307200 mod 65536 = 16'hB000 after a locked frame.

Source files
------------

// File: rtl/vga_capture.sv
// VGA 640x480 receive front end: sync edge tracking, pixel coordinates, timing lock FSM.
// Optional running pixel checksum is enabled with the VGA_CAPTURE_CHECKSUM_EN macro.
module vga_capture #(
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BP        = 48,
    parameter int unsigned H_TOTAL     = 800,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BP        = 33,
    parameter int unsigned V_TOTAL     = 525,
    parameter int unsigned LOCK_FRAMES = 2
) (
    input  logic        in_clock,
    input  logic        in_reset,
    input  logic        in_pixel_stb,
    input  logic        in_Hsync,
    input  logic        in_Vsync,
    input  logic [3:0]  in_r,
    input  logic [3:0]  in_g,
    input  logic [3:0]  in_b,
    output logic [9:0]  out_x,
    output logic [8:0]  out_y,
    output logic [3:0]  out_r,
    output logic [3:0]  out_g,
    output logic [3:0]  out_b,
    output logic        out_pixel_valid,
    output logic        out_frame_start,
    output logic        out_locked,
    output logic        out_err
`ifdef VGA_CAPTURE_CHECKSUM_EN
    ,
    output logic [15:0] out_checksum
`endif
);

    localparam logic [9:0]  H_START  = 10'(H_SYNC + H_BP);
    localparam logic [9:0]  H_END    = 10'(H_SYNC + H_BP + H_ACTIVE - 1);
    localparam logic [9:0]  V_START  = 10'(V_SYNC + V_BP);
    localparam logic [9:0]  V_END    = 10'(V_SYNC + V_BP + V_ACTIVE - 1);
    localparam logic [10:0] H_LEN    = 11'(H_TOTAL);
    localparam logic [10:0] V_LEN    = 11'(V_TOTAL);
    localparam logic [9:0]  HCNT_MAX = 10'd1023;
    localparam logic [3:0]  LOCK_CNT = 4'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        hsync_q, hsync_d, vsync_q, vsync_d;
    logic [9:0]  hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic [3:0]  good_q, good_d;
    logic        skip_q, skip_d;
    logic [9:0]  x_q, x_d;
    logic [8:0]  y_q, y_d;
    logic [3:0]  r_q, r_d, g_q, g_d, b_q, b_d;
    logic        valid_q, valid_d, fs_q, fs_d, locked_q, locked_d, err_q, err_d;

    logic        h_edge_s, v_edge_s, active_s, line_bad_s, frame_bad_s, bad_s, lost_s;
    logic [10:0] line_len_s, frame_len_s;
    logic [9:0]  y_full_s;

    // Sync edge detection, coordinate counters and length checks.
    always_comb begin
        h_edge_s = in_pixel_stb & hsync_q & ~in_Hsync;
        v_edge_s = in_pixel_stb & vsync_q & ~in_Vsync;
        hsync_d  = in_pixel_stb ? in_Hsync : hsync_q;
        vsync_d  = in_pixel_stb ? in_Vsync : vsync_q;

        if (!in_pixel_stb) begin
            hcnt_d = hcnt_q;
        end else if (h_edge_s) begin
            hcnt_d = 10'd0;
        end else if (hcnt_q != HCNT_MAX) begin
            hcnt_d = hcnt_q + 10'd1;
        end else begin
            hcnt_d = hcnt_q;
        end

        if (v_edge_s) begin
            vcnt_d = 10'd0;
        end else if (h_edge_s) begin
            vcnt_d = vcnt_q + 10'd1;
        end else begin
            vcnt_d = vcnt_q;
        end

        line_len_s  = {1'b0, hcnt_q} + 11'd1;
        // Vsync falls at the start of a line, so that strobe's Hsync edge closes the last line.
        frame_len_s = {1'b0, vcnt_q} + {10'd0, h_edge_s};
        line_bad_s  = h_edge_s & ~skip_q & (line_len_s != H_LEN);
        frame_bad_s = v_edge_s & (frame_len_s != V_LEN);
        bad_s       = line_bad_s | frame_bad_s;
        lost_s      = in_pixel_stb & (hcnt_d == HCNT_MAX);

        active_s = in_pixel_stb & (hcnt_d >= H_START) & (hcnt_d <= H_END)
                 & (vcnt_d >= V_START) & (vcnt_d <= V_END);
        y_full_s = vcnt_d - V_START;
    end

    // Lock FSM next state and registered output values.
    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        skip_d  = skip_q;
        err_d   = 1'b0;
        case (state_q)
            ST_SEARCH: begin
                skip_d = 1'b1;
                if (v_edge_s) begin
                    state_d = ST_MEASURE;
                    good_d  = 4'd0;
                end else begin
                    state_d = ST_SEARCH;
                end
            end
            ST_MEASURE: begin
                skip_d = h_edge_s ? 1'b0 : skip_q;
                if (bad_s) begin
                    err_d   = 1'b1;
                    state_d = ST_SEARCH;
                end else if (v_edge_s) begin
                    good_d  = good_q + 4'd1;
                    state_d = ((good_q + 4'd1) >= LOCK_CNT) ? ST_LOCKED : ST_MEASURE;
                end else begin
                    state_d = ST_MEASURE;
                end
            end
            ST_LOCKED: begin
                skip_d = h_edge_s ? 1'b0 : skip_q;
                if (bad_s | lost_s) begin
                    err_d   = 1'b1;
                    state_d = ST_SEARCH;
                end else begin
                    state_d = ST_LOCKED;
                end
            end
            default: begin
                state_d = ST_SEARCH;
            end
        endcase

        locked_d = (state_d == ST_LOCKED);
        valid_d  = active_s & locked_d;
        fs_d     = v_edge_s;
        if (active_s) begin
            x_d = hcnt_d - H_START;
            y_d = y_full_s[8:0];
            r_d = in_r;
            g_d = in_g;
            b_d = in_b;
        end else begin
            x_d = x_q;
            y_d = y_q;
            r_d = r_q;
            g_d = g_q;
            b_d = b_q;
        end
    end

    // State, counters and output registers.
    always_ff @(posedge in_clock or negedge in_reset) begin
        if (!in_reset) begin
            state_q  <= ST_SEARCH;
            hsync_q  <= 1'b1;
            vsync_q  <= 1'b1;
            hcnt_q   <= 10'd0;
            vcnt_q   <= 10'd0;
            good_q   <= 4'd0;
            skip_q   <= 1'b1;
            x_q      <= 10'd0;
            y_q      <= 9'd0;
            r_q      <= 4'd0;
            g_q      <= 4'd0;
            b_q      <= 4'd0;
            valid_q  <= 1'b0;
            fs_q     <= 1'b0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            hcnt_q   <= hcnt_d;
            vcnt_q   <= vcnt_d;
            good_q   <= good_d;
            skip_q   <= skip_d;
            x_q      <= x_d;
            y_q      <= y_d;
            r_q      <= r_d;
            g_q      <= g_d;
            b_q      <= b_d;
            valid_q  <= valid_d;
            fs_q     <= fs_d;
            locked_q <= locked_d;
            err_q    <= err_d;
        end
    end

    assign out_x           = x_q;
    assign out_y           = y_q;
    assign out_r           = r_q;
    assign out_g           = g_q;
    assign out_b           = b_q;
    assign out_pixel_valid = valid_q;
    assign out_frame_start = fs_q;
    assign out_locked      = locked_q;
    assign out_err         = err_q;

`ifdef VGA_CAPTURE_CHECKSUM_EN
    logic [15:0] acc_q, acc_d, ck_q, ck_d;
    logic [15:0] pix_s;

    // Accumulator only runs while locked so a relock never carries a partial frame.
    always_comb begin
        pix_s = valid_d ? {4'd0, in_r, in_g, in_b} : 16'd0;
        if (state_d != ST_LOCKED) begin
            acc_d = 16'd0;
            ck_d  = ck_q;
        end else if (v_edge_s && (state_q == ST_LOCKED)) begin
            acc_d = pix_s;
            ck_d  = acc_q;
        end else begin
            acc_d = acc_q + pix_s;
            ck_d  = ck_q;
        end
    end

    // Checksum registers.
    always_ff @(posedge in_clock or negedge in_reset) begin
        if (!in_reset) begin
            acc_q <= 16'd0;
            ck_q  <= 16'd0;
        end else begin
            acc_q <= acc_d;
            ck_q  <= ck_d;
        end
    end

    assign out_checksum = ck_q;
`endif

endmodule

// File: tb/tb_vga_capture.sv
// Scoreboard bench for vga_capture, run on a scaled-down video mode so whole frames stay short.
module tb_vga_capture;

    localparam int HS = 4, HB = 3, HA = 8, HT = 20;
    localparam int VS = 2, VB = 3, VA = 4, VT = 12;

    logic       clk = 1'b0, rst_n = 1'b0, stb = 1'b0, hs = 1'b1, vs = 1'b1;
    logic [3:0] r = 4'h0, g = 4'h0, b = 4'h0;
    logic [9:0] out_x;
    logic [8:0] out_y;
    logic [3:0] out_r, out_g, out_b;
    logic       out_pixel_valid, out_frame_start, out_locked, out_err;
`ifdef VGA_CAPTURE_CHECKSUM_EN
    logic [15:0] out_checksum;
    logic [15:0] last_sum = 16'h0;
`endif

    vga_capture #(
        .H_ACTIVE(HA), .H_SYNC(HS), .H_BP(HB), .H_TOTAL(HT),
        .V_ACTIVE(VA), .V_SYNC(VS), .V_BP(VB), .V_TOTAL(VT), .LOCK_FRAMES(2)
    ) dut (
        .in_clock(clk), .in_reset(rst_n), .in_pixel_stb(stb),
        .in_Hsync(hs), .in_Vsync(vs), .in_r(r), .in_g(g), .in_b(b),
        .out_x(out_x), .out_y(out_y), .out_r(out_r), .out_g(out_g), .out_b(out_b),
        .out_pixel_valid(out_pixel_valid), .out_frame_start(out_frame_start),
        .out_locked(out_locked), .out_err(out_err)
`ifdef VGA_CAPTURE_CHECKSUM_EN
        , .out_checksum(out_checksum)
`endif
    );

    always #10 clk = ~clk;

    typedef struct packed {
        logic [9:0] x;
        logic [8:0] y;
        logic [3:0] r, g, b;
    } pix_t;

    pix_t exp_q[$];
    int checks = 0, passes = 0;
    int fs_cnt = 0, err_cnt = 0, val_cnt = 0, lock_fs = 0;
    logic locked_prev = 1'b0, stb_seen = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    always @(posedge clk) stb_seen <= stb;

    // Monitor: pops one expected pixel per valid pulse; latency bit demands a strobe on the prior edge.
    always @(negedge clk) begin
        pix_t e;
        int pending;
        fs_cnt      <= fs_cnt + (out_frame_start ? 1 : 0);
        err_cnt     <= err_cnt + (out_err ? 1 : 0);
        locked_prev <= out_locked;
        if (out_locked && !locked_prev) lock_fs <= fs_cnt + (out_frame_start ? 1 : 0);
        if (out_pixel_valid) begin
            val_cnt <= val_cnt + 1;
            pending = exp_q.size();
            check("pixel_expected", (pending > 0), 1);
            if (pending > 0) begin
                e = exp_q.pop_front();
                check("pixel", {stb_seen, out_x, out_y, out_r, out_g, out_b}, {1'b1, e});
            end
        end
    end

    task automatic strobe(input logic h, input logic v, input logic [3:0] rr, gg, bb);
        @(negedge clk);
        hs = h; vs = v; r = rr; g = gg; b = bb; stb = 1'b1;
        @(negedge clk);
        stb = 1'b0;
    endtask

    task automatic do_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("reset_outputs", {out_x, out_y, out_r, out_g, out_b, out_pixel_valid,
                                out_frame_start, out_locked, out_err}, 64'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One frame; pixels on lines below valid_upto are expected while no reset has happened.
    task automatic frame(input int valid_upto, input int short_line, input int rst_line, input int rst_pos);
        bit vld = 1'b1;
`ifdef VGA_CAPTURE_CHECKSUM_EN
        logic [15:0] sum = 16'h0;
`endif
        for (int l = 0; l < VT; l++) begin
            int len;
            len = (l == short_line) ? HT - 1 : HT;
            for (int p = 0; p < len; p++) begin
                logic [9:0] x;
                logic [8:0] y;
                logic [3:0] cr, cg, cb;
                bit act;
                act = (p >= HS + HB) && (p < HS + HB + HA) && (l >= VS + VB) && (l < VS + VB + VA);
                x  = 10'(p - (HS + HB));
                y  = 9'(l - (VS + VB));
                cr = x[3:0];
                cg = y[3:0] ^ 4'h9;
                cb = x[3:0] + {y[1:0], 2'b01};
                if (x == 10'(HA - 1) && y == 9'(VA - 1)) {cr, cg, cb} = 12'hF0A;
                if (act && vld && l < valid_upto) begin
                    exp_q.push_back({x, y, cr, cg, cb});
`ifdef VGA_CAPTURE_CHECKSUM_EN
                    sum = sum + {4'h0, cr, cg, cb};
`endif
                end
                strobe(p >= HS, l >= VS, act ? cr : 4'h0, act ? cg : 4'h0, act ? cb : 4'h0);
                if (l == rst_line && p == rst_pos) begin
                    do_reset();
                    vld = 1'b0;
                end
            end
        end
`ifdef VGA_CAPTURE_CHECKSUM_EN
        last_sum = sum;
`endif
    endtask

    initial begin
        int v0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_state", {out_x, out_y, out_r, out_g, out_b, out_pixel_valid,
                              out_frame_start, out_locked, out_err}, 64'h0);
        rst_n = 1'b1;

        frame(0, -1, -1, -1);
        frame(0, -1, -1, -1);
        check("no_lock_after_2_edges", out_locked, 0);
        v0 = val_cnt;
        frame(VT, -1, -1, -1);
        check("lock_at_3rd_edge", lock_fs, 3);
        check("valid_per_frame", val_cnt - v0, HA * VA);
        check("err_none_yet", err_cnt, 0);

        frame(7, 6, -1, -1);
        check("err_short_line", err_cnt, 1);
        check("unlocked_after_short", out_locked, 0);
        frame(0, -1, -1, -1);
        frame(0, -1, -1, -1);
        check("still_unlocked", out_locked, 0);
        frame(VT, -1, -1, -1);
        check("relock_edge", lock_fs, 7);

        strobe(1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
        repeat (1100) strobe(1'b1, 1'b1, 4'h0, 4'h0, 4'h0);
        check("err_lost_hsync", err_cnt, 2);
        check("unlocked_lost_hsync", out_locked, 0);
        check("frame_starts_8", fs_cnt, 8);
`ifdef VGA_CAPTURE_CHECKSUM_EN
        check("checksum", out_checksum, last_sum);
`endif

        frame(0, -1, -1, -1);
        frame(0, -1, -1, -1);
        frame(VT, -1, 6, 10);
        check("no_fs_after_reset", fs_cnt, 11);
        check("unlocked_after_reset", out_locked, 0);
        frame(0, -1, -1, -1);
        check("fs_next_edge", fs_cnt, 12);
        check("queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
